// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding and width defaults for the conv sequencer
package cnn_pkg;
  localparam int DEF_FILTERNUM_WIDTH = 8;
  localparam int DEF_KERNELNUM_WIDTH = 8;
  localparam int DEF_DATANUM_WIDTH = 8;
  localparam int DEF_TIMESTEP_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_IN_STRIDE = 64;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;
endpackage

// File: rtl/cnn_loop_cnt.sv
// cnn_loop_cnt: cascaded t/f/k/d loop counters with per-level limits and wrap flags
module cnn_loop_cnt #(
  parameter int TW = 8,
  parameter int FW = 8,
  parameter int KW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic [TW-1:0] lim_t,
  input  logic [FW-1:0] lim_f,
  input  logic [KW-1:0] lim_k,
  input  logic [DW-1:0] lim_d,
  output logic [TW-1:0] t,
  output logic [FW-1:0] f,
  output logic [KW-1:0] k,
  output logic [DW-1:0] d,
  output logic          last_t,
  output logic          last_f,
  output logic          last_k,
  output logic          last_d
);
  assign last_t = t == lim_t - TW'(1);
  assign last_f = f == lim_f - FW'(1);
  assign last_k = k == lim_k - KW'(1);
  assign last_d = d == lim_d - DW'(1);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      t <= '0;
      f <= '0;
      k <= '0;
      d <= '0;
    end else if (adv) begin
      d <= last_d ? '0 : d + DW'(1);
      if (last_d) k <= last_k ? '0 : k + KW'(1);
      if (last_d && last_k) f <= last_f ? '0 : f + FW'(1);
      if (last_d && last_k && last_f) t <= last_t ? '0 : t + TW'(1);
    end
  end
endmodule

// File: rtl/cnn_conv_seq.sv
// cnn_conv_seq: convolution sequencer issuing MAC beats and output-memory writes
module cnn_conv_seq import cnn_pkg::*; #(
  parameter int FILTERNUM_WIDTH = DEF_FILTERNUM_WIDTH,
  parameter int KERNELNUM_WIDTH = DEF_KERNELNUM_WIDTH,
  parameter int DATANUM_WIDTH = DEF_DATANUM_WIDTH,
  parameter int TIMESTEP_WIDTH = DEF_TIMESTEP_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int IN_STRIDE = DEF_IN_STRIDE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [FILTERNUM_WIDTH-1:0] num_filter,
  input  logic [KERNELNUM_WIDTH-1:0] num_kernel,
  input  logic [DATANUM_WIDTH-1:0]   filter_length,
  input  logic [TIMESTEP_WIDTH-1:0]  num_total_conv,
  input  logic                       stall,
  input  logic                       acc_valid,
  output logic [ADDR_WIDTH-1:0]      inmem_addr,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  output logic                       mac_valid,
  output logic                       mac_first,
  output logic                       mac_last,
  output logic                       write_enable_a,
  output logic [ADDR_WIDTH-1:0]      outmem_addr,
  output logic                       busy,
  output logic                       conv
);
  state_t state, state_n;
  logic [FILTERNUM_WIDTH-1:0] cfg_f, f;
  logic [KERNELNUM_WIDTH-1:0] cfg_k, k;
  logic [DATANUM_WIDTH-1:0] cfg_d, d;
  logic [TIMESTEP_WIDTH-1:0] cfg_t, t;
  logic last_t, last_f, last_k, last_d;
  logic [ADDR_WIDTH-1:0] row_base, rom_cnt, out_cnt;
  logic start, zero_cfg, beat, end_filter, fin;
  assign start = state == IDLE && enable;
  assign zero_cfg = num_filter == '0 || num_kernel == '0 || filter_length == '0 || num_total_conv == '0;
  assign beat = state == ISSUE && !stall;
  assign end_filter = beat && last_k && last_d;
  cnn_loop_cnt #(
    .TW(TIMESTEP_WIDTH),
    .FW(FILTERNUM_WIDTH),
    .KW(KERNELNUM_WIDTH),
    .DW(DATANUM_WIDTH)
  ) u_cnt (
    .clk(clk),
    .rst(reset),
    .clr(start),
    .adv(beat),
    .lim_t(cfg_t),
    .lim_f(cfg_f),
    .lim_k(cfg_k),
    .lim_d(cfg_d),
    .t(t),
    .f(f),
    .k(k),
    .d(d),
    .last_t(last_t),
    .last_f(last_f),
    .last_k(last_k),
    .last_d(last_d)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (enable) state_n = zero_cfg ? DONE : ISSUE;
      ISSUE: if (end_filter) state_n = DRAIN;
      DRAIN: if (acc_valid) state_n = WRITE;
      WRITE: state_n = fin ? DONE : ISSUE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from state_n so strobes line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      {cfg_f, cfg_k, cfg_d, cfg_t} <= '0;
      {row_base, rom_cnt, out_cnt, fin} <= '0;
      {inmem_addr, rom_addr, outmem_addr} <= '0;
      {mac_valid, mac_first, mac_last, write_enable_a, busy, conv} <= '0;
    end else begin
      if (start) begin
        cfg_f <= num_filter;
        cfg_k <= num_kernel;
        cfg_d <= filter_length;
        cfg_t <= num_total_conv;
        {row_base, rom_cnt, out_cnt, fin} <= '0;
      end
      mac_valid <= beat;
      mac_first <= beat && k == '0 && d == '0;
      mac_last <= end_filter;
      if (beat) begin
        inmem_addr <= row_base + ADDR_WIDTH'(t) + ADDR_WIDTH'(d);
        rom_addr <= rom_cnt;
        rom_cnt <= (end_filter && last_f) ? '0 : rom_cnt + ADDR_WIDTH'(1);
        if (last_d) row_base <= last_k ? '0 : row_base + ADDR_WIDTH'(IN_STRIDE);
        if (end_filter) fin <= last_f && last_t;
      end
      write_enable_a <= state_n == WRITE;
      if (state_n == WRITE) outmem_addr <= out_cnt;
      if (state == WRITE) out_cnt <= out_cnt + ADDR_WIDTH'(1);
      busy <= state_n != IDLE;
      conv <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_cnn_conv_seq.sv
// tb_cnn_conv_seq: directed checks of beat order, stalls, drains, writes and reset abort
module tb_cnn_conv_seq;
  logic clk = 1'b0;
  logic reset, enable, stall, acc_valid, acc_force, acc_auto;
  logic [7:0] num_filter, num_kernel, filter_length, num_total_conv;
  logic [9:0] inmem_addr, rom_addr, outmem_addr;
  logic mac_valid, mac_first, mac_last, write_enable_a, busy, conv;
  int total = 0, bad = 0, cyc = 0;
  int nbeat, nwr, nconv, nfirst, nlast, wr_err, wr_cyc, conv_cyc, en_cyc, acc_cd, acc_dly;
  logic [9:0] in_q[$], rom_q[$];
  logic first_q[$], last_q[$];
  always #5 clk = ~clk;
  cnn_conv_seq dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .num_filter(num_filter),
    .num_kernel(num_kernel),
    .filter_length(filter_length),
    .num_total_conv(num_total_conv),
    .stall(stall),
    .acc_valid(acc_valid),
    .inmem_addr(inmem_addr),
    .rom_addr(rom_addr),
    .mac_valid(mac_valid),
    .mac_first(mac_first),
    .mac_last(mac_last),
    .write_enable_a(write_enable_a),
    .outmem_addr(outmem_addr),
    .busy(busy),
    .conv(conv)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic mon_clear();
    {nbeat, nwr, nconv, nfirst, nlast, wr_err, acc_cd} = '0;
    wr_cyc = -1;
    conv_cyc = -1;
    in_q.delete();
    rom_q.delete();
    first_q.delete();
    last_q.delete();
  endtask
  // One cycle: drive acc_valid from the responder and log what the DUT shows.
  task automatic step();
    @(negedge clk);
    cyc++;
    acc_valid = acc_force;
    if (acc_cd > 0) begin
      acc_cd--;
      if (acc_cd == 0) acc_valid = 1'b1;
    end
    if (mac_valid === 1'b1) begin
      nbeat++;
      in_q.push_back(inmem_addr);
      rom_q.push_back(rom_addr);
      first_q.push_back(mac_first);
      last_q.push_back(mac_last);
      nfirst += int'(mac_first);
      nlast += int'(mac_last);
      if (mac_last && acc_auto) acc_cd = acc_dly;
    end
    if (write_enable_a === 1'b1) begin
      if (outmem_addr !== 10'(nwr)) wr_err++;
      nwr++;
      wr_cyc = cyc;
    end
    if (conv === 1'b1) begin
      nconv++;
      conv_cyc = cyc;
    end
  endtask
  task automatic start(input logic [7:0] nf, input logic [7:0] nk, input logic [7:0] fl, input logic [7:0] nt);
    mon_clear();
    num_filter = nf;
    num_kernel = nk;
    filter_length = fl;
    num_total_conv = nt;
    enable = 1'b1;
    step();
    en_cyc = cyc;
    enable = 1'b0;
    {num_filter, num_kernel, filter_length, num_total_conv} = '1;
  endtask
  task automatic wait_conv(input int budget);
    int n = 0;
    while (nconv == 0 && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
  endtask
  task automatic wait_beats(input int want, input int budget);
    int n = 0;
    while (nbeat < want && n < budget) begin
      step();
      n++;
    end
    chk("beat_wait", 32'(nbeat >= want), 1);
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_inmem"}, inmem_addr, 0);
    chk({tag, "_rom"}, rom_addr, 0);
    chk({tag, "_outmem"}, outmem_addr, 0);
    chk({tag, "_valid"}, mac_valid, 0);
    chk({tag, "_first"}, mac_first, 0);
    chk({tag, "_last"}, mac_last, 0);
    chk({tag, "_we"}, write_enable_a, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_conv"}, conv, 0);
  endtask
  initial begin
    {reset, enable, stall, acc_valid, acc_force} = '0;
    {num_filter, num_kernel, filter_length, num_total_conv} = '0;
    acc_auto = 1'b1;
    acc_dly = 3;
    mon_clear();
    reset = 1'b1;
    repeat (3) step();
    chk_idle_outputs("rst");
    reset = 1'b0;
    step();
    // Single filter of two taps
    start(1, 1, 2, 1);
    wait_conv(50);
    chk("t1_beats", nbeat, 2);
    chk("t1_in0", in_q[0], 0);
    chk("t1_in1", in_q[1], 1);
    chk("t1_rom0", rom_q[0], 0);
    chk("t1_rom1", rom_q[1], 1);
    chk("t1_first", {first_q[0], first_q[1]}, 2'b10);
    chk("t1_last", {last_q[0], last_q[1]}, 2'b01);
    chk("t1_writes", nwr, 1);
    chk("t1_wr_order", wr_err, 0);
    chk("t1_convs", nconv, 1);
    chk("t1_conv_lat", conv_cyc - wr_cyc, 1);
    chk("t1_busy_end", busy, 0);
    // Zero filter count skips straight to done
    start(0, 1, 1, 1);
    wait_conv(10);
    chk("t2_beats", nbeat, 0);
    chk("t2_writes", nwr, 0);
    chk("t2_convs", nconv, 1);
    chk("t2_conv_lat", 32'(conv_cyc - en_cyc <= 2), 1);
    // Stall holds issue after the first beat
    acc_dly = 2;
    start(1, 1, 4, 1);
    wait_beats(1, 20);
    stall = 1'b1;
    repeat (3) begin
      step();
      chk("t3_stall_valid", mac_valid, 0);
      chk("t3_stall_rom", rom_addr, 0);
      chk("t3_stall_in", inmem_addr, 0);
    end
    stall = 1'b0;
    wait_conv(50);
    chk("t3_beats", nbeat, 4);
    chk("t3_rom", {rom_q[0], rom_q[1], rom_q[2], rom_q[3]}, {10'd0, 10'd1, 10'd2, 10'd3});
    chk("t3_in", {in_q[0], in_q[1], in_q[2], in_q[3]}, {10'd0, 10'd1, 10'd2, 10'd3});
    chk("t3_writes", nwr, 1);
    // Large run
    start(32, 4, 16, 16);
    wait_conv(45000);
    chk("t4_beats", nbeat, 32768);
    chk("t4_writes", nwr, 512);
    chk("t4_wr_order", wr_err, 0);
    chk("t4_firsts", nfirst, 512);
    chk("t4_lasts", nlast, 512);
    chk("t4_convs", nconv, 1);
    chk("t4_k1_in", in_q[16], 64);
    chk("t4_t1_rom", rom_q[2048], 0);
    chk("t4_t1_in", in_q[2048], 1);
    chk("t4_end_rom", rom_q[32767], 1023);
    chk("t4_end_in", in_q[32767], 222);
    // Reset during issue aborts, then a rerun completes
    start(2, 2, 4, 2);
    wait_beats(3, 20);
    reset = 1'b1;
    step();
    chk_idle_outputs("t5_abort");
    reset = 1'b0;
    repeat (5) step();
    chk("t5_no_write", nwr, 0);
    chk("t5_no_conv", nconv, 0);
    start(2, 2, 4, 2);
    wait_conv(200);
    chk("t5_beats", nbeat, 32);
    chk("t5_writes", nwr, 4);
    chk("t5_wr_order", wr_err, 0);
    chk("t5_convs", nconv, 1);
    // acc_valid during issue is ignored
    acc_auto = 1'b0;
    start(1, 1, 4, 1);
    wait_beats(2, 20);
    acc_force = 1'b1;
    step();
    acc_force = 1'b0;
    wait_beats(4, 20);
    repeat (4) step();
    chk("t6_no_early_write", nwr, 0);
    chk("t6_busy_drain", busy, 1);
    acc_force = 1'b1;
    step();
    acc_force = 1'b0;
    wait_conv(20);
    chk("t6_writes", nwr, 1);
    chk("t6_wr_order", wr_err, 0);
    chk("t6_convs", nconv, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
